// File: rtl/serial_link_perf_pkg.sv
// Shared types for the serial link performance counters.
//   perf_state_e    : controller state encoding (also exported on state_o)
//   perf_evt_t      : per-channel event decode for one cycle
//   PerfMaxChannels : largest supported channel count
package serial_link_perf_pkg;

  localparam int unsigned PerfMaxChannels = 8;

  typedef enum logic [1:0] {
    PERF_IDLE  = 2'd0,
    PERF_RUN   = 2'd1,
    PERF_FLUSH = 2'd2
  } perf_state_e;

  // Stall is decoded separately so builds without stall counters carry no
  // dangling bits.
  typedef struct packed {
    logic vld;
    logic xfer;
    logic cred;
  } perf_evt_t;

  function automatic perf_evt_t perf_decode(input logic v, input logic r, input logic c);
    perf_evt_t e;
    e.vld  = v;
    e.xfer = v & r;
    e.cred = v & r & c;
    return e;
  endfunction

endpackage

// File: rtl/serial_link_perf_sat_cnt.sv
// One saturating event counter.
//   en_i       : count this cycle (ignored once at all-ones)
//   clr_i      : synchronous zero, highest priority
//   load_i     : synchronous load of load_val_i
//   cnt_inc_o  : current count plus this cycle's increment (saturated);
//                this is what the register takes absent clr/load, and is
//                what a snapshot taken this cycle must see.
module serial_link_perf_sat_cnt
  #(parameter int unsigned Width = 32)
  (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic [Width-1:0] cnt_inc_o
  );

  logic [Width-1:0] cnt_q;

  assign cnt_inc_o = (en_i && (cnt_q != '1)) ? cnt_q + Width'(1) : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else             cnt_q <= cnt_inc_o;
  end

endmodule

// File: rtl/serial_link_perf_counters.sv
// Per-channel valid/transfer/stall/credit-only event counters over a
// programmable cycle window, with a frozen snapshot handed out on a
// valid/ready handshake.
//   clk_i, rst_ni         : link clock, async active-low reset
//   enable_i, clear_i     : run/hold, synchronous clear of live counters
//   win_len_i             : window length (0 = free-running, no snapshots),
//                           latched when leaving IDLE
//   valid_i/ready_i/cred_only_i : monitored channels
//   snap_*                : snapshot handshake and data
//   overrun_o             : sticky, window ended with snapshot unaccepted
//   state_o               : controller state for debug
// Build option: define SERIAL_LINK_PERF_STALL_EN to build stall counters;
// otherwise snap_stall_cnt_o is tied to zero.
module serial_link_perf_counters
  import serial_link_perf_pkg::*;
  #(
    parameter int unsigned NumChannels = 3,
    parameter int unsigned CntWidth    = 32,
    parameter int unsigned WinWidth    = 24
  )
  (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  enable_i,
    input  logic                                  clear_i,
    input  logic [WinWidth-1:0]                   win_len_i,
    input  logic [NumChannels-1:0]                valid_i,
    input  logic [NumChannels-1:0]                ready_i,
    input  logic [NumChannels-1:0]                cred_only_i,
    output logic                                  snap_valid_o,
    input  logic                                  snap_ready_i,
    output logic [CntWidth-1:0]                   snap_cycles_o,
    output logic [NumChannels-1:0][CntWidth-1:0]  snap_valid_cnt_o,
    output logic [NumChannels-1:0][CntWidth-1:0]  snap_xfer_cnt_o,
    output logic [NumChannels-1:0][CntWidth-1:0]  snap_stall_cnt_o,
    output logic [NumChannels-1:0][CntWidth-1:0]  snap_cred_cnt_o,
    output logic                                  overrun_o,
    output logic [1:0]                            state_o
  );

  typedef logic [CntWidth-1:0]    cnt_t;
  typedef cnt_t [NumChannels-1:0] cnt_vec_t;
  typedef struct packed {
    cnt_t     cycles;
    cnt_vec_t vld;
    cnt_vec_t xfer;
    cnt_vec_t cred;
  } snap_t;

  perf_state_e         state_q, state_d;
  logic [WinWidth-1:0] len_q, win_q;
  logic                snap_valid_q, overrun_q;
  snap_t               snap_q;

  logic start, count_en, win_end, capture, drop, live_clr;

  // Events in a clear cycle are discarded, so clear also masks window-end.
  assign start    = (state_q == PERF_IDLE) && enable_i;
  assign count_en = (state_q == PERF_RUN) && enable_i && !clear_i;
  assign win_end  = count_en && (len_q != '0) && (win_q == len_q - WinWidth'(1));
  // An accept in the window-end cycle frees the slot for the new snapshot.
  assign capture  = win_end && (!snap_valid_q || snap_ready_i);
  assign drop     = win_end && snap_valid_q && !snap_ready_i;
  assign live_clr = clear_i || win_end;

  // Controller
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= PERF_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PERF_IDLE:  if (enable_i) state_d = PERF_RUN;
      PERF_RUN: begin
        if (!enable_i) state_d = PERF_IDLE;
        else if (drop) state_d = PERF_FLUSH;
      end
      PERF_FLUSH: state_d = PERF_RUN;
      default:    state_d = PERF_IDLE;
    endcase
  end

  // Window length and position
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q <= '0;
      win_q <= '0;
    end else begin
      if (start) len_q <= win_len_i;
      if (start || live_clr) win_q <= '0;
      else if (count_en)     win_q <= win_q + WinWidth'(1);
    end
  end

  // Live counters
  cnt_t     cyc_inc;
  cnt_vec_t vld_inc, xfer_inc, cred_inc;

  serial_link_perf_sat_cnt #(.Width(CntWidth)) u_cyc (
    .clk_i, .rst_ni, .en_i(count_en), .clr_i(live_clr),
    .load_i(1'b0), .load_val_i('0), .cnt_inc_o(cyc_inc)
  );

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    perf_evt_t evt;
    assign evt = perf_decode(valid_i[c], ready_i[c], cred_only_i[c]);

    serial_link_perf_sat_cnt #(.Width(CntWidth)) u_vld (
      .clk_i, .rst_ni, .en_i(count_en & evt.vld), .clr_i(live_clr),
      .load_i(1'b0), .load_val_i('0), .cnt_inc_o(vld_inc[c])
    );
    serial_link_perf_sat_cnt #(.Width(CntWidth)) u_xfer (
      .clk_i, .rst_ni, .en_i(count_en & evt.xfer), .clr_i(live_clr),
      .load_i(1'b0), .load_val_i('0), .cnt_inc_o(xfer_inc[c])
    );
    serial_link_perf_sat_cnt #(.Width(CntWidth)) u_cred (
      .clk_i, .rst_ni, .en_i(count_en & evt.cred), .clr_i(live_clr),
      .load_i(1'b0), .load_val_i('0), .cnt_inc_o(cred_inc[c])
    );
  end

  // Snapshot and handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (capture) begin
        snap_q       <= '{cycles: cyc_inc, vld: vld_inc, xfer: xfer_inc, cred: cred_inc};
        snap_valid_q <= 1'b1;
      end else if (snap_ready_i) begin
        snap_valid_q <= 1'b0;
      end
      if (drop) overrun_q <= 1'b1;
    end
  end

`ifdef SERIAL_LINK_PERF_STALL_EN
  cnt_vec_t stall_inc, stall_q;

  for (genvar c = 0; c < NumChannels; c++) begin : g_stall
    serial_link_perf_sat_cnt #(.Width(CntWidth)) u_stall (
      .clk_i, .rst_ni, .en_i(count_en & valid_i[c] & ~ready_i[c]), .clr_i(live_clr),
      .load_i(1'b0), .load_val_i('0), .cnt_inc_o(stall_inc[c])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      stall_q <= '0;
    else if (capture) stall_q <= stall_inc;
  end

  assign snap_stall_cnt_o = stall_q;
`else
  assign snap_stall_cnt_o = '0;
`endif

  assign snap_valid_o     = snap_valid_q;
  assign snap_cycles_o    = snap_q.cycles;
  assign snap_valid_cnt_o = snap_q.vld;
  assign snap_xfer_cnt_o  = snap_q.xfer;
  assign snap_cred_cnt_o  = snap_q.cred;
  assign overrun_o        = overrun_q;
  assign state_o          = state_q;

endmodule
